// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller for the 5-stage core.
//   - EX-stage operand forwarding selects (00 = register file, 01 = WB result,
//     10 = MEM result; 11 is never produced).
//   - Stall / flush controls for the IF/ID/EX/MEM pipeline registers
//     (memory busy > taken branch > load-use).
//   - Data-memory wait-state tracker (RUN / MEM_WAIT) with a sticky timeout
//     flag for a memory that never answers.
//
// Optional build macro: HAZARD_PERF_EN adds saturating performance counters
//   perf_stall_cnt (cycles with stall_f) and perf_flush_cnt (cycles with a
//   branch-induced flush_e), plus the PERF_WIDTH parameter.
//
// Ports
//   clk                  core clock, all state on rising edge
//   rst_n                synchronous active-low reset
//   rs1_d, rs2_d         source registers of the instruction in ID
//   rs1_e, rs2_e, rd_e   source / destination registers in EX
//   mem_read_e           EX instruction is a load
//   rd_m, reg_write_m    MEM destination / write enable
//   rd_w, reg_write_w    WB destination / write enable
//   pc_src_e             taken branch/jump resolved in EX
//   mem_req_m            MEM instruction accesses data memory
//   mem_ready_m          data memory completes the access this cycle
//   forward_a, forward_b forwarding mux selects for EX operands
//   stall_f..stall_m     hold PC, IF-ID, ID-EX, EX-MEM registers
//   flush_d, flush_e     bubble IF-ID, ID-EX registers
//   mem_wait             tracker is in MEM_WAIT (registered)
//   mem_timeout_err      sticky memory-timeout flag (registered)
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 255
`ifdef HAZARD_PERF_EN
  , parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      mem_read_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  input  logic                      pc_src_e,
  input  logic                      mem_req_m,
  input  logic                      mem_ready_m,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      mem_wait,
  output logic                      mem_timeout_err
`ifdef HAZARD_PERF_EN
  , output logic [PERF_WIDTH-1:0]   perf_stall_cnt
  , output logic [PERF_WIDTH-1:0]   perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Forwarding: index 0 = operand A (rs1_e), index 1 = operand B (rs2_e).
  // The MEM stage holds the younger result, so it wins over WB on the same rd.
  // -------------------------------------------------------------------------
  logic [1:0][REG_ADDR_WIDTH-1:0] rs_e;
  logic [1:0][1:0]                fwd_sel;

  assign rs_e = {rs2_e, rs1_e};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m;
      logic hit_w;
      assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e[gi]);
      assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e[gi]);
      assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
    end
  endgenerate

  assign forward_a = rst_n ? fwd_sel[0] : 2'b00;
  assign forward_b = rst_n ? fwd_sel[1] : 2'b00;

  // -------------------------------------------------------------------------
  // Stall / flush priority
  // -------------------------------------------------------------------------
  logic lu_hazard;
  logic mem_busy;

  assign lu_hazard = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign mem_busy  = mem_req_m && !mem_ready_m;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst_n) begin
      // Keep bubbles flowing into ID/EX while the core is held in reset.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_busy) begin
      // Freeze the whole front of the pipe; nothing may be lost or duplicated.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (pc_src_e) begin
      // The load in EX (if any) is on the wrong path after a taken branch.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_hazard) begin
      // Hold IF/ID one cycle and inject a single bubble into EX.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Memory wait tracker. Stalls above are driven directly from mem_busy so a
  // one-cycle miss costs exactly one cycle; this FSM only observes the wait.
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_reg, timeout_next;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_m || !mem_req_m) begin
          // Completed or aborted request.
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == CNT_MAX) begin
          // Counter sits at its ceiling; a still-busy memory is declared stuck.
          timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign mem_wait        = (state_reg == MEM_WAIT);
  assign mem_timeout_err = timeout_reg;

`ifdef HAZARD_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters.
  // -------------------------------------------------------------------------
  logic [PERF_WIDTH-1:0] stall_cnt_reg;
  logic [PERF_WIDTH-1:0] flush_cnt_reg;
  logic                  branch_flush;

  // flush_e caused by a taken branch (memory stalls take priority over it).
  assign branch_flush = rst_n && !mem_busy && pc_src_e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_f && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (branch_flush && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Directed self-checking bench for hazard_unit (MEM_TIMEOUT = 4).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge. One line is printed per check.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       mem_read_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m;
  logic [1:0] forward_a, forward_b;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic       mem_wait, mem_timeout_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  logic [5:0] ctrl;
  assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_WIDTH(5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_wait(mem_wait), .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    mem_read_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
    mem_req_m = 0; mem_ready_m = 0;
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point).
  task automatic smp();
    @(negedge clk);
  endtask

  // ctrl bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
  initial begin
    // ---------------- reset ----------------
    clr();
    rst_n = 0;
    rd_m = 5; reg_write_m = 1; rs1_e = 5;     // would forward if not in reset
    mem_req_m = 1; mem_ready_m = 0;            // would stall if not in reset
    smp();
    chk("rst_ctrl", 32'(ctrl), 32'b000011);
    chk("rst_fwd_a", 32'(forward_a), 32'd0);
    nxt(); smp();
    chk("rst_wait", 32'(mem_wait), 32'd0);
    chk("rst_tmo", 32'(mem_timeout_err), 32'd0);

    // ---------------- forwarding ----------------
    nxt(); clr(); rst_n = 1;
    rd_m = 5; reg_write_m = 1; rs1_e = 5; rd_w = 5; reg_write_w = 1;
    smp();
    chk("fwd_a_mem", 32'(forward_a), 32'b10);
    chk("fwd_b_rf", 32'(forward_b), 32'b00);
    chk("fwd_ctrl0", 32'(ctrl), 32'b000000);

    nxt(); reg_write_m = 0;
    smp();
    chk("fwd_a_wb", 32'(forward_a), 32'b01);

    nxt(); reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
    smp();
    chk("fwd_a_x0", 32'(forward_a), 32'b00);

    nxt(); clr(); rs1_e = 3; rs2_e = 9; rd_m = 9; reg_write_m = 1; rd_w = 3; reg_write_w = 1;
    smp();
    chk("fwd_a_wb2", 32'(forward_a), 32'b01);
    chk("fwd_b_mem", 32'(forward_b), 32'b10);

    // ---------------- load-use / branch ----------------
    nxt(); clr(); mem_read_e = 1; rd_e = 7; rs2_d = 7;
    smp();
    chk("lu_stall", 32'(ctrl), 32'b110001);
    nxt(); mem_read_e = 0;
    smp();
    chk("lu_release", 32'(ctrl), 32'b000000);

    nxt(); mem_read_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
    smp();
    chk("lu_x0", 32'(ctrl), 32'b000000);

    nxt(); clr(); mem_read_e = 1; rd_e = 12; rs1_d = 12;
    smp();
    chk("lu_rs1", 32'(ctrl), 32'b110001);

    nxt(); pc_src_e = 1;                      // load-use still present
    smp();
    chk("br_over_lu", 32'(ctrl), 32'b000011);

    nxt(); clr(); pc_src_e = 1;
    smp();
    chk("br_flush", 32'(ctrl), 32'b000011);
    nxt();                                    // third branch flush
    smp();
    chk("br_flush2", 32'(ctrl), 32'b000011);
    nxt(); clr();
    smp();
    chk("idle_ctrl", 32'(ctrl), 32'b000000);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'd2);
    chk("perf_flush", perf_flush_cnt, 32'd3);
`endif

    // ---------------- 3-cycle memory wait ----------------
    nxt(); mem_req_m = 1; mem_ready_m = 0;
    pc_src_e = 1; mem_read_e = 1; rd_e = 4; rs1_d = 4;   // memory busy has top priority
    smp();
    chk("mw_c1_ctrl", 32'(ctrl), 32'b111100);
    chk("mw_c1_wait", 32'(mem_wait), 32'd0);
    nxt(); pc_src_e = 0; mem_read_e = 0;
    smp();
    chk("mw_c2_ctrl", 32'(ctrl), 32'b111100);
    chk("mw_c2_wait", 32'(mem_wait), 32'd1);
    nxt();
    smp();
    chk("mw_c3_ctrl", 32'(ctrl), 32'b111100);
    chk("mw_c3_wait", 32'(mem_wait), 32'd1);
    nxt(); mem_ready_m = 1;
    smp();
    chk("mw_c4_ctrl", 32'(ctrl), 32'b000000);
    chk("mw_c4_wait", 32'(mem_wait), 32'd1);
    nxt(); clr();
    smp();
    chk("mw_c5_wait", 32'(mem_wait), 32'd0);
    chk("mw_c5_tmo", 32'(mem_timeout_err), 32'd0);

    // ---------------- aborted request ----------------
    nxt(); mem_req_m = 1;
    smp();
    nxt(); mem_req_m = 0;
    smp();
    chk("abort_wait", 32'(mem_wait), 32'd1);
    chk("abort_ctrl", 32'(ctrl), 32'b000000);
    nxt();
    smp();
    chk("abort_run", 32'(mem_wait), 32'd0);

    // ---------------- timeout (MEM_TIMEOUT = 4) ----------------
    // wait_cnt reaches 4 after the 4th busy edge; the 5th busy edge sets the flag.
    nxt(); mem_req_m = 1; mem_ready_m = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("tmo_pre%0d", i), 32'(mem_timeout_err), 32'd0);
      nxt();
    end
    smp();
    chk("tmo_set", 32'(mem_timeout_err), 32'd1);
    nxt(); mem_req_m = 0;
    smp();
    nxt();
    smp();
    chk("tmo_sticky", 32'(mem_timeout_err), 32'd1);
    chk("tmo_run", 32'(mem_wait), 32'd0);

    // ---------------- reset mid-wait ----------------
    nxt(); mem_req_m = 1;
    smp();
    nxt();
    smp();
    chk("mid_wait", 32'(mem_wait), 32'd1);
    nxt(); rst_n = 0;                          // memory still busy
    smp();
    chk("rst_sync_tmo", 32'(mem_timeout_err), 32'd1);
    chk("rst_sync_wt", 32'(mem_wait), 32'd1);
    nxt(); rst_n = 1; clr();
    smp();
    chk("rst_clr_tmo", 32'(mem_timeout_err), 32'd0);
    chk("rst_clr_wait", 32'(mem_wait), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
